alu_arb_ctrl: RTL and testbench

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 25 ++
 rtl/alu_arb_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_arb_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code and controller state definitions for the arbitrated ALU.
package alu_pkg;
  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_EQ  = 3'b110,
    OP_CLR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_e;
endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU; results wrap mod 256, no carry/borrow out.
import alu_pkg::*;

module alu_core (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  always_comb begin
    result = '0;
    case (alu_op_e'(sel))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_EQ:   result = (a == b) ? 8'h01 : 8'h00;
      default: result = '0;
    endcase
    zero = (result == '0);
  end
endmodule

// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end sharing one ALU: IDLE grants, EXEC computes,
// RESP holds the registered result until the owner takes it.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid is held with stable payload until that edge, ready may change freely.
import alu_pkg::*;

module alu_arb_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [5:0]       req_sel,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);
  ctrl_state_e       state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [2:0]        sel_q, sel_d;
  logic [7:0]        data_q, data_d;
  logic              zero_q, zero_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       gnt_idx;
  logic       grant;
  logic       rsp_hs;
  logic [7:0] alu_result;
  logic       alu_zero;

  // Contention goes to the pointer; a lone requester wins regardless of it.
  always_comb begin
    gnt_idx = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    grant   = (state_q == ST_IDLE) && (req_valid != 2'b00);
    rsp_hs  = (state_q == ST_RESP) && rsp_ready[owner_q];
  end

  alu_core u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    data_d  = data_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    if (grant) begin
      owner_d = gnt_idx;
      a_d     = gnt_idx ? req_a[15:8]  : req_a[7:0];
      b_d     = gnt_idx ? req_b[15:8]  : req_b[7:0];
      sel_d   = gnt_idx ? req_sel[5:3] : req_sel[2:0];
    end
    if (state_q == ST_EXEC) begin
      data_d = alu_result;
      zero_d = alu_zero;
    end
    // Priority moves away from whoever was just served.
    if (rsp_hs) begin
      ptr_d = ~owner_q;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (grant) req_ready[gnt_idx] = 1'b1;
    if (state_q == ST_RESP) rsp_valid[owner_q] = 1'b1;
    busy      = (state_q != ST_IDLE);
    rsp_data  = data_q;
    rsp_zero  = zero_q;
    op_count  = cnt_q;
    dbg_state = state_q;
  end
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed plus random bench for alu_arb_ctrl; a 16-bit and a 4-bit counter instance share stimulus.
module tb_alu_arb_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [5:0]  req_sel;
  logic [1:0]  rsp_ready;

  logic [1:0]  req_ready, req_ready4;
  logic [1:0]  rsp_valid, rsp_valid4;
  logic [7:0]  rsp_data, rsp_data4;
  logic        rsp_zero, rsp_zero4;
  logic        busy, busy4;
  logic [15:0] op_count16;
  logic [3:0]  op_count4;
  logic [1:0]  dbg_state, dbg_state4;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cnt      = 0;
  logic last_served = 1'b1;
  logic exp_owner   = 1'b0;
  logic [7:0] exp_data = 8'h00;

  always #5 clk = ~clk;

  alu_arb_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy), .op_count(op_count16), .dbg_state(dbg_state)
  );

  alu_arb_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .rsp_valid(rsp_valid4),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data4), .rsp_zero(rsp_zero4),
    .busy(busy4), .op_count(op_count4), .dbg_state(dbg_state4)
  );

  function automatic logic [7:0] ref_alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    int x, y, r;
    x = int'(a);
    y = int'(b);
    case (s)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = 255 - x;
      3'd6: r = (x == y) ? 1 : 0;
      default: r = 0;
    endcase
    r = ((r % 256) + 256) % 256;
    return 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag);
    chk({tag, "_cnt16"}, 32'(op_count16), 32'(cnt % 65536));
    chk({tag, "_cnt4"},  32'(op_count4),  32'(cnt % 16));
  endtask

  task automatic check_resp(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), exp_owner ? 32'h2 : 32'h1);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'(exp_data));
    chk({tag, "_rsp_zero"},  32'(rsp_zero),  (exp_data == 8'h00) ? 32'h1 : 32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h1);
    chk({tag, "_data4"},     32'(rsp_data4), 32'(exp_data));
  endtask

  // Presents requests in IDLE, checks the grant, and returns one cycle later in EXEC.
  task automatic start_op(input logic [1:0] v,
                          input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] s0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] s1);
    logic own;
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_sel   = {s1, s0};
    #1;
    own       = (v == 2'b11) ? ~last_served : v[1];
    exp_owner = own;
    exp_data  = own ? ref_alu(s1, a1, b1) : ref_alu(s0, a0, b0);
    chk("grant_ready", 32'(req_ready), own ? 32'h2 : 32'h1);
    chk("idle_busy",   32'(busy),      32'h0);
    step();
    req_valid[own] = 1'b0;
    chk("exec_ready",     32'(req_ready), 32'h0);
    chk("exec_busy",      32'(busy),      32'h1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'h0);
  endtask

  // Moves into RESP, stalls with only the non-owner ready bit set, then completes.
  task automatic finish_op(input int stall);
    step();
    check_resp("resp");
    for (int i = 0; i < stall; i++) begin
      rsp_ready = exp_owner ? 2'b01 : 2'b10;
      step();
      check_resp("stall");
      chk("stall_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = exp_owner ? 2'b10 : 2'b01;
    step();
    rsp_ready   = 2'b00;
    cnt++;
    last_served = exp_owner;
    chk("done_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("done_busy",      32'(busy),      32'h0);
    check_count("done");
  endtask

  task automatic reset_and_check(input string tag);
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rsp_ready = 2'b00;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'h0);
    chk({tag, "_rsp_zero"},  32'(rsp_zero),  32'h1);
    cnt = 0;
    last_served = 1'b1;
    check_count(tag);
    rst = 1'b0;
  endtask

  task automatic random_op();
    logic [1:0] v;
    v = 2'($urandom_range(1, 3));
    start_op(v, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    finish_op(int'($urandom_range(0, 3)));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_a = '0;
    req_b = '0;
    req_sel = '0;
    rsp_ready = 2'b00;
    step();
    step();
    reset_and_check("reset");

    // Single requester add
    start_op(2'b01, 8'h0A, 8'h05, 3'b000, 8'h00, 8'h00, 3'b000);
    finish_op(0);

    // Round-robin under contention, then the loser is served without re-arbitration loss
    reset_and_check("reset_rr");
    start_op(2'b11, 8'h0A, 8'h03, 3'b001, 8'hF0, 8'h0F, 3'b011);
    finish_op(0);
    start_op(2'b10, 8'h00, 8'h00, 3'b000, 8'hF0, 8'h0F, 3'b011);
    finish_op(0);
    start_op(2'b11, 8'h0A, 8'h03, 3'b001, 8'hF0, 8'h0F, 3'b011);
    finish_op(1);

    // Back-pressure on requester 1 while requester 0 waits
    start_op(2'b10, 8'h11, 8'h22, 3'b000, 8'h55, 8'h00, 3'b101);
    req_valid = 2'b01;
    finish_op(5);
    start_op(2'b01, 8'h11, 8'h22, 3'b000, 8'h00, 8'h00, 3'b000);
    finish_op(0);

    // Zero flag, equality and subtract wrap
    start_op(2'b01, 8'h0A, 8'h0A, 3'b110, 8'h00, 8'h00, 3'b000);
    finish_op(0);
    start_op(2'b10, 8'h00, 8'h00, 3'b000, 8'hFF, 8'hFF, 3'b100);
    finish_op(0);
    start_op(2'b01, 8'h00, 8'h01, 3'b001, 8'h00, 8'h00, 3'b000);
    finish_op(2);

    // Reset in RESP colliding with the response handshake
    start_op(2'b01, 8'h12, 8'h34, 3'b000, 8'h00, 8'h00, 3'b000);
    step();
    rsp_ready = 2'b01;
    reset_and_check("rst_resp");

    // Reset in EXEC
    start_op(2'b10, 8'h00, 8'h00, 3'b000, 8'h77, 8'h01, 3'b000);
    reset_and_check("rst_exec");
    start_op(2'b11, 8'h80, 8'h80, 3'b000, 8'h01, 8'h01, 3'b000);
    finish_op(0);

    for (int i = 0; i < 40; i++) random_op();

    // Exactly sixteen completions after reset wrap the 4-bit counter
    reset_and_check("reset_wrap");
    for (int i = 0; i < 16; i++) random_op();
    chk("wrap_cnt4",  32'(op_count4),  32'h0);
    chk("wrap_cnt16", 32'(op_count16), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
